huff_chunk_encoder: RTL and testbench

// Streaming Huffman encoder; transmit-side counterpart of shift_reg decoder (MAX_CODE=9).

---
 rtl/huff_chunk_encoder_if.sv | 24 ++
 rtl/huff_chunk_encoder.sv | 153 +++++++++++++++
 tb/tb_huff_chunk_encoder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/huff_chunk_encoder_if.sv
// Handshake bundle for the Huffman chunk encoder: symbol input and chunk output streams.
// The slave modport is the encoder's view. The master modport is the view of whoever
// feeds symbols and drains chunks.
interface huff_chunk_encoder_if;
    logic              sValid;
    logic              sReady;
    logic signed [3:0] sData;
    logic              sLast;
    logic              mValid;
    logic              mReady;
    logic        [3:0] out_bits;
    logic        [2:0] out_len;
    logic              mLast;

    modport slave (
        input  sValid, sData, sLast, mReady,
        output sReady, mValid, out_bits, out_len, mLast
    );

    modport master (
        output sValid, sData, sLast, mReady,
        input  sReady, mValid, out_bits, out_len, mLast
    );
endinterface

// File: rtl/huff_chunk_encoder.sv
// Streaming Huffman encoder.
// Signed 4-bit samples are mapped to prefix codewords and packed MSB-first into an
// accumulator. The accumulator is drained as 1..4-bit chunks. Only full 4-bit chunks
// leave while in RUN. FLUSH, entered on the last symbol, drains the remainder and marks
// the final chunk with mLast.
module huff_chunk_encoder #(
    parameter int MAX_CODE = 9,
    parameter int ACC_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    huff_chunk_encoder_if.slave    bus
);
    localparam int CW = $clog2(ACC_W + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic [3:0] len;
        logic [8:0] code;   // right-aligned codeword
    } cw_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;      // oldest bit at MSB, unused low bits zero
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                rdy_en_q;
    logic                ovld_q, ovld_d;
    logic [3:0]          obits_q, obits_d;
    logic [2:0]          olen_q, olen_d;
    logic                olast_q, olast_d;

    logic                s_ready, accept, m_xfer, load, is_final;
    logic [2:0]          take;
    cw_t                 cw;
    logic [MAX_CODE-1:0] code_l;
    logic [ACC_W-1:0]    code_al;
    logic [CW-1:0]       keep;
    logic [3:0]          code_len;

    // Fixed shared codebook. The sample is matched on its two's-complement bit pattern.
    function automatic cw_t encode(input logic [3:0] s);
        cw_t r;
        case (s)
            4'b0000: r = '{len: 4'd2, code: 9'b000000000};  //  0 : 00
            4'b0001: r = '{len: 4'd3, code: 9'b000000010};  //  1 : 010
            4'b1111: r = '{len: 4'd3, code: 9'b000000011};  // -1 : 011
            4'b0010: r = '{len: 4'd3, code: 9'b000000100};  //  2 : 100
            4'b1110: r = '{len: 4'd4, code: 9'b000001010};  // -2 : 1010
            4'b0011: r = '{len: 4'd4, code: 9'b000001011};  //  3 : 1011
            4'b1101: r = '{len: 4'd5, code: 9'b000011000};  // -3 : 11000
            4'b0100: r = '{len: 4'd5, code: 9'b000011001};  //  4 : 11001
            4'b1100: r = '{len: 4'd5, code: 9'b000011010};  // -4 : 11010
            4'b0101: r = '{len: 4'd6, code: 9'b000110110};  //  5 : 110110
            4'b1011: r = '{len: 4'd6, code: 9'b000110111};  // -5 : 110111
            4'b0110: r = '{len: 4'd6, code: 9'b000111000};  //  6 : 111000
            4'b1010: r = '{len: 4'd7, code: 9'b001110010};  // -6 : 1110010
            4'b0111: r = '{len: 4'd7, code: 9'b001110011};  //  7 : 1110011
            4'b1000: r = '{len: 4'd8, code: 9'b011101000};  // -8 : 11101000
            default: r = '{len: 4'd9, code: 9'b111010010};  // -7 : 111010010
        endcase
        return r;
    endfunction

    // State register plus the ready-enable flag that keeps sReady low during reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Next state: the last symbol starts a flush, and handing off the mLast chunk ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && bus.sLast) state_d = FLUSH;
            FLUSH:   if (m_xfer && olast_q)   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs: input readiness, and how many bits leave the accumulator this cycle.
    always_comb begin
        s_ready  = rdy_en_q && (state_q == RUN) && (cnt_q <= CW'(ACC_W - MAX_CODE));
        accept   = bus.sValid && s_ready;
        m_xfer   = ovld_q && bus.mReady;
        load     = (!ovld_q || bus.mReady) &&
                   ((cnt_q >= CW'(4)) || ((state_q == FLUSH) && (cnt_q != '0)));
        take     = 3'd0;
        if (load) take = (cnt_q >= CW'(4)) ? 3'd4 : cnt_q[2:0];
        is_final = (state_q == FLUSH) && (cnt_q <= CW'(4));
    end

    // Accumulator update: shift out the extracted bits, then append the new codeword
    // directly behind the bits that remain.
    always_comb begin
        cw       = encode(bus.sData);
        code_l   = cw.code << (4'(MAX_CODE) - cw.len);
        code_al  = {code_l, {(ACC_W - MAX_CODE){1'b0}}};
        keep     = cnt_q - CW'(take);
        code_len = accept ? cw.len : 4'd0;
        acc_d    = (acc_q << take) | (accept ? (code_al >> keep) : '0);
        cnt_d    = keep + CW'(code_len);
    end

    // Output register: load a new chunk when the slot is free. Otherwise clear it after a
    // transfer, or hold it while the consumer stalls.
    always_comb begin
        ovld_d  = ovld_q;
        obits_d = obits_q;
        olen_d  = olen_q;
        olast_d = olast_q;
        if (load) begin
            ovld_d  = 1'b1;
            obits_d = acc_q[ACC_W-1 -: 4] >> (3'd4 - take);
            olen_d  = take;
            olast_d = is_final;
        end else if (m_xfer) begin
            ovld_d  = 1'b0;
            obits_d = 4'd0;
            olen_d  = 3'd0;
            olast_d = 1'b0;
        end
    end

    // Datapath and output registers; reset discards buffered bits and any pending chunk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ovld_q  <= 1'b0;
            obits_q <= 4'd0;
            olen_q  <= 3'd0;
            olast_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovld_q  <= ovld_d;
            obits_q <= obits_d;
            olen_q  <= olen_d;
            olast_q <= olast_d;
        end
    end

    assign bus.sReady   = s_ready;
    assign bus.mValid   = ovld_q;
    assign bus.out_bits = obits_q;
    assign bus.out_len  = olen_q;
    assign bus.mLast    = olast_q;
endmodule

// File: tb/tb_huff_chunk_encoder.sv
// Bench for huff_chunk_encoder. It applies a table of short streams with hand-derived
// chunks, then checks reset, latency, backpressure, a mid-flush reset and a random run
// against a bit-queue model of the codebook.
module tb_huff_chunk_encoder;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    huff_chunk_encoder_if bus();

    huff_chunk_encoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] b;
        int         len;
        bit         last;
    } exp_t;

    typedef struct {
        int              nsym;
        logic [2:0][3:0] sym;
        int              nch;
        logic [2:0][3:0] cbits;
        logic [2:0][2:0] clen;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    bit   mq[$];
    bit   rnd_mr = 0;

    bit         hold_q = 0;
    logic [3:0] hold_b;
    logic [2:0] hold_l;
    logic       hold_m;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic string cb(input int v);
        case (v)
            0: return "00";         1: return "010";       -1: return "011";
            2: return "100";       -2: return "1010";       3: return "1011";
           -3: return "11000";      4: return "11001";     -4: return "11010";
            5: return "110110";    -5: return "110111";     6: return "111000";
           -6: return "1110010";    7: return "1110011";   -8: return "11101000";
            default: return "111010010";
        endcase
    endfunction

    function automatic void push_chunk(input int n, input bit last);
        logic [3:0] b = 4'd0;
        for (int i = 0; i < n; i++) b = {b[2:0], mq.pop_front()};
        sb.push_back('{b: b, len: n, last: last});
    endfunction

    function automatic void model_push(input logic [3:0] s, input bit last);
        int    v = int'($signed(s));
        string c = cb(v);
        for (int i = 0; i < c.len(); i++) mq.push_back(c[i] == "1");
        while (mq.size() > 4) push_chunk(4, 0);
        if (last) push_chunk(mq.size(), 1);
    endfunction

    function automatic vec_t mk(input int ns, input int s0, input int s1, input int s2,
                                input int nc, input logic [3:0] b0, input int l0,
                                input logic [3:0] b1, input int l1,
                                input logic [3:0] b2, input int l2);
        vec_t r;
        r.nsym = ns;   r.nch = nc;
        r.sym[0] = 4'(s0); r.sym[1] = 4'(s1); r.sym[2] = 4'(s2);
        r.cbits[0] = b0; r.cbits[1] = b1; r.cbits[2] = b2;
        r.clen[0] = 3'(l0); r.clen[1] = 3'(l1); r.clen[2] = 3'(l2);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a symbol until it is accepted (bounded); optionally feed the model.
    task automatic send(input logic [3:0] s, input bit last, input bit use_model);
        bit acc = 0;
        int cyc = 0;
        bus.sValid = 1'b1;
        bus.sData  = s;
        bus.sLast  = last;
        while (!acc && cyc < 100) begin
            @(negedge clk);
            acc = bus.sReady;
            @(posedge clk);
            #1;
            if (rnd_mr) bus.mReady = 1'($urandom_range(0, 1));
            cyc++;
        end
        bus.sValid = 1'b0;
        bus.sLast  = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got sReady=0 for %0d cycles expected 1", cyc);
        end else if (use_model) begin
            model_push(s, last);
        end
    endtask

    task automatic drain();
        bus.mReady = 1'b1;
        for (int c = 0; c < 200 && sb.size() != 0; c++) tick();
        tick();
        tick();
        chk("drain_empty", sb.size(), 0);
        chk("drain_idle_mValid", bus.mValid, 0);
    endtask

    // Chunk monitor: compares each transfer with the scoreboard and checks that stalled
    // chunks stay stable.
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_q = 0;
        end else begin
            if (hold_q) begin
                total++;
                if (!(bus.mValid && bus.out_bits == hold_b && bus.out_len == hold_l &&
                      bus.mLast == hold_m)) begin
                    bad++;
                    $display("FAIL hold: got v=%0d bits=%b len=%0d last=%0d expected v=1 bits=%b len=%0d last=%0d",
                             bus.mValid, bus.out_bits, bus.out_len, bus.mLast, hold_b, hold_l, hold_m);
                end
            end
            if (bus.mValid && bus.mReady) begin
                exp_t e;
                int   mask;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL chunk_unexpected: got bits=%b len=%0d expected no chunk",
                             bus.out_bits, bus.out_len);
                end else begin
                    e    = sb.pop_front();
                    mask = (1 << e.len) - 1;
                    if (int'(bus.out_len) != e.len || bus.mLast != e.last ||
                        (int'(bus.out_bits) & mask) != (int'(e.b) & mask)) begin
                        bad++;
                        $display("FAIL chunk: got bits=%b len=%0d last=%0d expected bits=%b len=%0d last=%0d",
                                 bus.out_bits, bus.out_len, bus.mLast, e.b, e.len, e.last);
                    end
                end
            end
            hold_q = bus.mValid && !bus.mReady;
            hold_b = bus.out_bits;
            hold_l = bus.out_len;
            hold_m = bus.mLast;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = mk(2,  0,  0, 0, 1, 4'b0000, 4, 4'b0000, 0, 4'b0000, 0);
        vecs[1] = mk(1, -7,  0, 0, 3, 4'b1110, 4, 4'b1001, 4, 4'b0000, 1);
        vecs[2] = mk(3,  0,  1, 2, 2, 4'b0001, 4, 4'b0100, 4, 4'b0000, 0);
        vecs[3] = mk(2,  3, -3, 0, 3, 4'b1011, 4, 4'b1100, 4, 4'b0000, 1);
        vecs[4] = mk(3,  5, -1, 1, 3, 4'b1101, 4, 4'b1001, 4, 4'b1010, 4);
        vecs[5] = mk(1, -6,  0, 0, 2, 4'b1110, 4, 4'b0010, 3, 4'b0000, 0);

        reset_n    = 1'b0;
        bus.sValid = 1'b0;
        bus.sData  = 4'sd0;
        bus.sLast  = 1'b0;
        bus.mReady = 1'b0;
        repeat (3) tick();
        chk("rst_mValid", bus.mValid, 0);
        chk("rst_out_len", bus.out_len, 0);
        chk("rst_out_bits", bus.out_bits, 0);
        chk("rst_mLast", bus.mLast, 0);
        chk("rst_sReady", bus.sReady, 0);
        reset_n = 1'b1;
        #1;
        chk("sReady_before_first_clk", bus.sReady, 0);
        tick();
        chk("sReady_after_first_clk", bus.sReady, 1);

        // Table of short streams with hand-derived chunks.
        bus.mReady = 1'b1;
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < vecs[v].nch; j++)
                sb.push_back('{b: vecs[v].cbits[j], len: int'(vecs[v].clen[j]),
                               last: (j == vecs[v].nch - 1)});
            for (int i = 0; i < vecs[v].nsym; i++)
                send(vecs[v].sym[i], i == vecs[v].nsym - 1, 0);
            drain();
        end

        // Latency: an accepted 9-bit codeword gives mValid two edges later.
        send(4'(-7), 1, 1);
        @(negedge clk);
        chk("latency_edge1_mValid", bus.mValid, 0);
        @(negedge clk);
        chk("latency_edge2_mValid", bus.mValid, 1);
        tick();
        drain();

        // Backpressure: with mReady low, sReady drops once the buffer fills.
        bus.mReady = 1'b0;
        send(4'(-8), 0, 1);
        send(4'(-8), 0, 1);
        repeat (6) tick();
        chk("stall_sReady", bus.sReady, 0);
        chk("stall_mValid", bus.mValid, 1);
        chk("stall_out_len", bus.out_len, 4);
        chk("stall_out_bits", bus.out_bits, 4'b1110);
        bus.mReady = 1'b1;
        send(4'(-8), 1, 1);
        drain();

        // Reset during FLUSH with a pending chunk.
        bus.mReady = 1'b0;
        send(4'(-7), 1, 1);
        repeat (3) tick();
        chk("flush_pending_mValid", bus.mValid, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_mValid", bus.mValid, 0);
        chk("midrst_out_len", bus.out_len, 0);
        chk("midrst_mLast", bus.mLast, 0);
        sb.delete();
        mq.delete();
        tick();
        reset_n = 1'b1;
        tick();
        bus.mReady = 1'b1;
        send(4'd0, 0, 1);
        send(4'd0, 1, 1);
        drain();

        // Random run of two streams with random backpressure.
        rnd_mr = 1;
        for (int i = 0; i < 64; i++)
            send(4'($urandom_range(0, 15)), (i == 31) || (i == 63), 1);
        rnd_mr = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
